// File: rtl/vector_accumulator.sv
// Multi-channel integrate-and-dump accumulator: sums acc_len frames per channel in a
// per-channel store and emits one result per channel after the last frame of each integration.
module vector_accumulator #(
  parameter int INPUT_DATA_WIDTH  = 18,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int N_CHAN            = 16,
  parameter int ACC_LEN_WIDTH     = 16,
  parameter int SIGNED            = 1,
  parameter int SATURATE          = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic                                     sync_in,
  input  logic [INPUT_DATA_WIDTH-1:0]              data_in,
  input  logic [ACC_LEN_WIDTH-1:0]                 acc_len,
  output logic [OUTPUT_DATA_WIDTH-1:0]             data_out,
  output logic                                     valid_out,
  output logic [$clog2(N_CHAN > 1 ? N_CHAN : 2)-1:0] chan_out,
  output logic                                     sync_out,
  output logic                                     ovf_out,
  output logic                                     sync_err
);
  localparam int IW = INPUT_DATA_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam int AW = ACC_LEN_WIDTH;
  localparam int CW = $clog2(N_CHAN > 1 ? N_CHAN : 2);
  localparam logic [CW-1:0] LAST_CHAN = CW'(N_CHAN - 1);

  typedef enum logic {WAIT_SYNC, ACCUM} state_t;

  state_t          state_reg;
  logic [CW-1:0]   chan_reg;
  logic [AW-1:0]   frame_reg;
  logic [AW-1:0]   len_reg;

  logic            start, accept, at_origin, last_frame, resync;
  logic [CW-1:0]   cur_chan;
  logic [AW-1:0]   cur_frame, eff_len;
  logic [OW-1:0]   ext_data;

  logic            s1_valid;
  logic [OW-1:0]   s1_data;
  logic [CW-1:0]   s1_chan;
  logic            s1_first, s1_last;

  // Store word is {sticky ovf, accumulated value}; depth rounded up to the index range.
  logic [OW:0]     store [2**CW];
  logic [OW:0]     rd_reg;

  logic [OW-1:0]   acc_val, sat_val, sum_next;
  logic            acc_ovf, add_ovf, ovf_next;
  logic [OW:0]     full_sum;

  // Input stage: a sync always restarts at channel 0 / frame 0, regardless of the counters.
  always_comb begin
    start      = en && sync_in;
    accept     = en && (sync_in || state_reg == ACCUM);
    cur_chan   = start ? '0 : chan_reg;
    cur_frame  = start ? '0 : frame_reg;
    at_origin  = (cur_chan == '0) && (cur_frame == '0);
    eff_len    = len_reg;
    if (at_origin) eff_len = (acc_len == '0) ? AW'(1) : acc_len;
    last_frame = (cur_frame == eff_len - AW'(1));
    resync     = start && (state_reg == ACCUM) && ((chan_reg != '0) || (frame_reg != '0));
    ext_data   = (SIGNED != 0 && data_in[IW-1]) ? '1 : '0;
    ext_data[IW-1:0] = data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WAIT_SYNC;
      chan_reg  <= '0;
      frame_reg <= '0;
      len_reg   <= AW'(1);
      s1_valid  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= resync;
      s1_valid <= accept;
      if (accept) begin
        state_reg <= ACCUM;
        len_reg   <= eff_len;
        if (cur_chan == LAST_CHAN) begin
          chan_reg  <= '0;
          frame_reg <= last_frame ? '0 : cur_frame + AW'(1);
        end else begin
          chan_reg  <= cur_chan + CW'(1);
          frame_reg <= cur_frame;
        end
      end
    end
  end

  // Store read is registered alongside stage 1; a same-channel write in flight is bypassed.
  always_ff @(posedge clk) begin
    if (s1_valid) store[s1_chan] <= {ovf_next, sum_next};
    if (accept) begin
      rd_reg   <= (s1_valid && s1_chan == cur_chan) ? {ovf_next, sum_next} : store[cur_chan];
      s1_data  <= ext_data;
      s1_chan  <= cur_chan;
      s1_first <= (cur_frame == '0);
      s1_last  <= last_frame;
    end
  end

  always_comb begin
    acc_val  = rd_reg[OW-1:0];
    acc_ovf  = rd_reg[OW];
    full_sum = {1'b0, acc_val} + {1'b0, s1_data};
    if (SIGNED != 0) begin
      add_ovf = (acc_val[OW-1] == s1_data[OW-1]) && (full_sum[OW-1] != acc_val[OW-1]);
      sat_val = acc_val[OW-1] ? '0 : '1;
      sat_val[OW-1] = acc_val[OW-1];
    end else begin
      add_ovf = full_sum[OW];
      sat_val = '1;
    end
    if (s1_first) begin
      sum_next = s1_data;
      ovf_next = 1'b0;
    end else begin
      sum_next = (add_ovf && SATURATE != 0) ? sat_val : full_sum[OW-1:0];
      ovf_next = acc_ovf | add_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      sync_out  <= 1'b0;
      data_out  <= '0;
      chan_out  <= '0;
      ovf_out   <= 1'b0;
    end else begin
      valid_out <= s1_valid && s1_last;
      sync_out  <= s1_valid && s1_last && (s1_chan == '0);
      if (s1_valid && s1_last) begin
        data_out <= sum_next;
        chan_out <= s1_chan;
        ovf_out  <= ovf_next;
      end
    end
  end
endmodule

// File: tb/tb_vector_accumulator.sv
// Directed bench: a 4-channel 18/32-bit instance plus two 1-channel 8-bit instances
// (saturating and wrapping) sharing stimulus.
module tb_vector_accumulator;
  typedef struct {
    int          cyc;
    logic [31:0] data;
    int          chan;
    logic        sync;
    logic        ovf;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          serr_cnt = 0;

  logic        en_a = 1'b0, sync_a = 1'b0;
  logic [17:0] data_a = '0;
  logic [15:0] len_a = 16'd3;
  logic [31:0] dout_a;
  logic        valid_a, sout_a, ovf_a, serr_a;
  logic [1:0]  chan_a;

  logic        en_b = 1'b0, sync_b = 1'b0;
  logic [7:0]  data_b = '0;
  logic [15:0] len_b = 16'd4;
  logic [7:0]  dout_s, dout_w;
  logic        valid_s, sout_s, ovf_s, serr_s, chan_s;
  logic        valid_w, sout_w, ovf_w, serr_w, chan_w;

  rec_t mq_a[$], eq_a[$], mq_s[$], eq_s[$], mq_w[$], eq_w[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_accumulator #(.INPUT_DATA_WIDTH(18), .OUTPUT_DATA_WIDTH(32), .N_CHAN(4),
                       .ACC_LEN_WIDTH(16), .SIGNED(1), .SATURATE(1)) u_main (
    .clk(clk), .rst(rst), .en(en_a), .sync_in(sync_a), .data_in(data_a), .acc_len(len_a),
    .data_out(dout_a), .valid_out(valid_a), .chan_out(chan_a), .sync_out(sout_a),
    .ovf_out(ovf_a), .sync_err(serr_a));

  vector_accumulator #(.INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(8), .N_CHAN(1),
                       .ACC_LEN_WIDTH(16), .SIGNED(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en_b), .sync_in(sync_b), .data_in(data_b), .acc_len(len_b),
    .data_out(dout_s), .valid_out(valid_s), .chan_out(chan_s), .sync_out(sout_s),
    .ovf_out(ovf_s), .sync_err(serr_s));

  vector_accumulator #(.INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(8), .N_CHAN(1),
                       .ACC_LEN_WIDTH(16), .SIGNED(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en_b), .sync_in(sync_b), .data_in(data_b), .acc_len(len_b),
    .data_out(dout_w), .valid_out(valid_w), .chan_out(chan_w), .sync_out(sout_w),
    .ovf_out(ovf_w), .sync_err(serr_w));

  always @(negedge clk) begin
    if (valid_a) mq_a.push_back('{cyc, dout_a, int'(chan_a), sout_a, ovf_a});
    if (valid_s) mq_s.push_back('{cyc, {24'd0, dout_s}, int'(chan_s), sout_s, ovf_s});
    if (valid_w) mq_w.push_back('{cyc, {24'd0, dout_w}, int'(chan_w), sout_w, ovf_w});
    if (serr_a) serr_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_rec(input string tag, input rec_t g, input rec_t e);
    $display("dump %s: cyc=%0d chan=%0d data=%0h sync=%0b ovf=%0b", tag, g.cyc, g.chan,
             g.data, g.sync, g.ovf);
    check({tag, ".cyc"},  g.cyc,  e.cyc);
    check({tag, ".data"}, g.data, e.data);
    check({tag, ".chan"}, g.chan, e.chan);
    check({tag, ".sync"}, g.sync, e.sync);
    check({tag, ".ovf"},  g.ovf,  e.ovf);
  endtask

  task automatic drain_a(input string tag);
    rec_t g, e;
    check({tag, ".count"}, mq_a.size(), eq_a.size());
    while (mq_a.size() > 0 && eq_a.size() > 0) begin
      g = mq_a.pop_front();
      e = eq_a.pop_front();
      compare_rec(tag, g, e);
    end
    mq_a.delete();
    eq_a.delete();
  endtask

  task automatic drain_b(input string tag);
    rec_t g, e;
    check({tag, ".sat.count"}, mq_s.size(), eq_s.size());
    while (mq_s.size() > 0 && eq_s.size() > 0) begin
      g = mq_s.pop_front();
      e = eq_s.pop_front();
      compare_rec({tag, ".sat"}, g, e);
    end
    check({tag, ".wrap.count"}, mq_w.size(), eq_w.size());
    while (mq_w.size() > 0 && eq_w.size() > 0) begin
      g = mq_w.pop_front();
      e = eq_w.pop_front();
      compare_rec({tag, ".wrap"}, g, e);
    end
    mq_s.delete(); eq_s.delete(); mq_w.delete(); eq_w.delete();
  endtask

  task automatic step_a(input logic e, input logic s, input int d, input int len, output int dc);
    @(negedge clk);
    en_a = e; sync_a = s; data_a = d[17:0]; len_a = len[15:0];
    dc = cyc;
  endtask

  task automatic idle_a(input int n);
    int dc;
    repeat (n) step_a(1'b0, 1'b0, 0, int'(len_a), dc);
  endtask

  task automatic expect_a(input int dc, input int d, input int c, input logic o);
    eq_a.push_back('{dc + 2, d, c, (c == 0), o});
  endtask

  task automatic step_b(input logic s, input int d, output int dc);
    @(negedge clk);
    en_b = 1'b1; sync_b = s; data_b = d[7:0]; len_b = 16'd4;
    dc = cyc;
  endtask

  initial begin
    int dc;
    int tbl [8];
    tbl = '{7, -3, 100, 0, -131072, 131071, 1, -1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.valid", valid_a, 1'b0);
    check("rst.data",  dout_a, 32'd0);
    check("rst.chan",  chan_a, 2'd0);
    check("rst.sync",  sout_a, 1'b0);
    check("rst.ovf",   ovf_a, 1'b0);
    check("rst.serr",  serr_a, 1'b0);
    rst = 1'b0;

    // Pre-sync samples dropped, then 3 frames with en continuous.
    repeat (3) step_a(1'b1, 1'b0, 55, 3, dc);
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        step_a(1'b1, (f == 0 && c == 0), c + 1, 3, dc);
        if (f == 2) expect_a(dc, 3 * (c + 1), c, 1'b0);
      end
    idle_a(4);
    drain_a("cont");

    // Same integration with en toggling every cycle.
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        step_a(1'b1, (f == 0 && c == 0), c + 1, 3, dc);
        if (f == 2) expect_a(dc, 3 * (c + 1), c, 1'b0);
        step_a(1'b0, 1'b0, 0, 3, dc);
      end
    idle_a(4);
    drain_a("toggle");
    check("serr.none", serr_cnt, 0);

    // acc_len 3 -> 5 mid-integration, then 0 (every frame dumps).
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        step_a(1'b1, (f == 0 && c == 0), c + 1, (f == 0 && c == 0) ? 3 : 5, dc);
        if (f == 2) expect_a(dc, 3 * (c + 1), c, 1'b0);
      end
    for (int f = 0; f < 5; f++)
      for (int c = 0; c < 4; c++) begin
        step_a(1'b1, 1'b0, c + 1, (f == 0 && c == 0) ? 5 : 0, dc);
        if (f == 4) expect_a(dc, 5 * (c + 1), c, 1'b0);
      end
    for (int i = 0; i < 8; i++) begin
      step_a(1'b1, 1'b0, tbl[i], 0, dc);
      expect_a(dc, tbl[i], i % 4, 1'b0);
    end
    idle_a(4);
    drain_a("acclen");

    // Resync at chan 2 of frame 1 aborts; new integration starts with that sample.
    for (int i = 0; i < 6; i++) step_a(1'b1, (i == 0), 50, 3, dc);
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        step_a(1'b1, (f == 0 && c == 0), c + 1, 3, dc);
        if (f == 2) expect_a(dc, 3 * (c + 1), c, 1'b0);
      end
    idle_a(4);
    drain_a("resync");
    check("serr.once", serr_cnt, 1);

    // Reset during the last frame kills everything in flight.
    for (int i = 0; i < 9; i++) step_a(1'b1, (i == 0), 20, 3, dc);
    @(negedge clk);
    rst = 1'b1; en_a = 1'b1; sync_a = 1'b0; data_a = 18'd9;
    @(negedge clk);
    rst = 1'b0; en_a = 1'b0;
    idle_a(4);
    drain_a("rst_abort");
    repeat (2) step_a(1'b1, 1'b0, 77, 3, dc);
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        step_a(1'b1, (f == 0 && c == 0), 10 * (c + 1), 3, dc);
        if (f == 2) expect_a(dc, 30 * (c + 1), c, 1'b0);
      end
    idle_a(4);
    drain_a("after_rst");
    check("serr.final", serr_cnt, 1);

    // 8-bit single channel: positive overflow, clean follow-up, negative overflow.
    for (int i = 0; i < 4; i++) step_b((i == 0), 100, dc);
    eq_s.push_back('{dc + 2, 32'h7F, 0, 1'b1, 1'b1});
    eq_w.push_back('{dc + 2, 32'h90, 0, 1'b1, 1'b1});
    for (int i = 0; i < 4; i++) step_b(1'b0, 1, dc);
    eq_s.push_back('{dc + 2, 32'h04, 0, 1'b1, 1'b0});
    eq_w.push_back('{dc + 2, 32'h04, 0, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) step_b(1'b0, -100, dc);
    eq_s.push_back('{dc + 2, 32'h80, 0, 1'b1, 1'b1});
    eq_w.push_back('{dc + 2, 32'h70, 0, 1'b1, 1'b1});
    @(negedge clk);
    en_b = 1'b0;
    repeat (4) @(negedge clk);
    drain_b("narrow");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_accumulator.md
Name: vector_accumulator

Overview:
- Multi-channel integrate-and-dump accumulator for time-multiplexed DSP streams, e.g. a spectrometer's FFT output with one channel per clock.
- For each of N_CHAN interleaved channels it sums acc_len consecutive frames in an internal per-channel store.
- After the last frame it emits one result per channel, then starts the next integration with no dead cycles.
- Sits after the FFT/power stage and before the packetiser. Adds signed/unsigned mode, saturation, overflow flags, runtime integration length and sync-based framing.

Parameters:
- INPUT_DATA_WIDTH, 18: input sample width.
- OUTPUT_DATA_WIDTH, 32: accumulator and output width. Must be >= INPUT_DATA_WIDTH.
- N_CHAN, 16: channels per frame. Must be >= 1; need not be a power of 2.
- ACC_LEN_WIDTH, 16: width of the acc_len port.
- SIGNED, 1: 1 = two's-complement data with sign extension; 0 = unsigned with zero extension.
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap modulo 2^OUTPUT_DATA_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  input sample strobe; data_in and sync_in are accepted only when en=1.
- sync_in  in  1  marks the accepted sample as channel 0 of frame 0 of a new integration.
- data_in  in  INPUT_DATA_WIDTH  input sample.
- acc_len  in  ACC_LEN_WIDTH  frames per integration; sampled at integration start.
- data_out  out  OUTPUT_DATA_WIDTH  accumulated result.
- valid_out  out  1  data_out, chan_out, sync_out and ovf_out are valid this cycle.
- chan_out  out  clog2(max(N_CHAN,2))  channel index of data_out.
- sync_out  out  1  qualifies channel 0 of each dump (only when valid_out=1).
- ovf_out  out  1  this channel overflowed (clamped or wrapped) at least once during this integration.
- sync_err  out  1  one-cycle pulse: sync_in arrived while the channel or frame counters were not at 0/0.

Behaviour:
- Reset:
  - All outputs 0; state WAIT_SYNC; channel and frame counters 0.
  - Pipeline valid bits cleared, so an in-flight sample never emerges.
  - Store contents are don't-care; the first frame overwrites them.
- States:
  - WAIT_SYNC: samples with en=1 and sync_in=0 are dropped. en=1 with sync_in=1 goes to ACCUM; that sample is channel 0, frame 0. No sync_err is raised from WAIT_SYNC.
  - ACCUM: each en=1 sample takes the current channel index. The channel counter increments and wraps N_CHAN-1 -> 0. On wrap the frame counter increments; if it was len_q-1 it wraps to 0. ACCUM is never left except by rst.
- acc_len latch:
  - len_q <= max(acc_len, 1), latched on each sample that is channel 0 of frame 0.
  - acc_len = 0 behaves as 1.
  - Changes to acc_len mid-integration have no effect.
- Resync: sync_in=1 with en=1 in ACCUM while (chan, frame) != (0, 0):
  - sync_err pulses for 1 cycle.
  - The integration is aborted; no dump is emitted for the aborted partial channels.
  - The sample restarts as channel 0, frame 0.
  - sync_in at exactly (0, 0) is legal and silent.
- Pipeline, fixed latency 2 cycles from accepted sample to valid_out. en=0 inserts bubbles and does not stall.
  - Stage 1 registers the extended sample, channel, first-frame flag and last-frame flag.
  - Stage 2 reads store[chan] (value + sticky ovf bit). Sum = first ? ext(data) : store + ext(data). It writes store[chan] and registers the outputs.
  - Back-to-back same-channel accesses (N_CHAN=1) must be correct: the store write in stage 2 is visible to the next stage-2 read.
- Arithmetic:
  - Extension follows SIGNED.
  - Overflow for SIGNED=1: operands of equal sign give a result of different sign. Overflow for SIGNED=0: carry out.
  - SATURATE=1 clamps to max/min representable; SATURATE=0 wraps.
  - Sticky ovf = (first ? 0 : stored ovf) | overflow this add.
- Dump: valid_out=1 only for samples in the last frame (frame == len_q-1).
  - data_out = sum; ovf_out = sticky ovf; chan_out = channel.
  - sync_out = (channel == 0).
  - The next integration's frame 0 overwrites the store, so no clear cycle is needed.
- With en held high: one dump of N_CHAN consecutive valid_out cycles every len_q*N_CHAN cycles.

Test Plan:
- N_CHAN=4, SIGNED=1, acc_len=3, en=1 continuous, sync at t0, data = channel index + 1 -> valid_out on the 3rd frame only, 2 cycles after each sample. data_out = 3, 6, 9, 12; sync_out on chan 0 only.
- Same setup, en toggled 1/0 each cycle -> identical results; each valid_out exactly 2 cycles after its accepted sample.
- SIGNED=1, OUTPUT_DATA_WIDTH=8, INPUT_DATA_WIDTH=8, acc_len=4, N_CHAN=1, data=+100. With SATURATE=1: data_out=127, ovf_out=1. With SATURATE=0: data_out = 400 mod 256 = 144 = -112 signed, ovf_out=1. Next integration with data=1: ovf_out=0.
- acc_len changed 3->5 mid-integration -> current dump still uses 3 frames, the next uses 5. acc_len=0 -> dump every frame with data_out = data_in.
- Extra sync_in at chan 2 of frame 1 -> sync_err pulses once, no valid_out for the aborted integration, and the new integration dumps correctly len_q frames later. Samples before the first sync are ignored.
- rst asserted for 1 cycle during the last frame -> no valid_out afterwards. Then WAIT_SYNC; the next sync_in starts a clean integration with results equal to the golden model.
